// File: rtl/idc_pulse_scheduler.sv
// Loop filter and pulse sequencer in front of the IDCounter DCO: K-counter, signed correction queue, spaced inc/dec pulses.
// Optional lock detector is enabled by defining IDC_LOCK_DET_EN.
module idc_pulse_scheduler #(
  parameter int K_MOD       = 15,
  parameter int MIN_GAP     = 4,
  parameter int PEND_MAX    = 3,
  parameter int LOCK_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clr,
  input  logic              up,
  input  logic              dn,
  output logic              inc,
  output logic              dec,
  output logic signed [2:0] pending,
  output logic              busy,
  output logic              ovf,
  output logic              lock
);
  localparam int KW = $clog2(K_MOD + 1);
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [KW-1:0]     K_MID = KW'(K_MOD / 2);
  localparam logic [KW-1:0]     K_TOP = KW'(K_MOD);
  localparam logic signed [4:0] PMAX  = 5'(PEND_MAX);
  localparam logic signed [4:0] PMIN  = -PMAX;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t              state_q;
  logic [KW-1:0]       kcnt_q, kcnt_d;
  logic [GW-1:0]       gap_q;
  logic signed [2:0]   pend_q, pend_d;
  logic signed [4:0]   pend_sum;
  logic                carry, borrow, issue, drop;
  logic                inc_q, dec_q, ovf_q;

  always_comb begin
    kcnt_d = kcnt_q;
    carry  = 1'b0;
    borrow = 1'b0;
    if (enable && up && !dn) begin
      if (kcnt_q == K_TOP) begin
        kcnt_d = K_MID;
        carry  = 1'b1;
      end else begin
        kcnt_d = kcnt_q + 1'b1;
      end
    end else if (enable && dn && !up) begin
      if (kcnt_q == '0) begin
        kcnt_d = K_MID;
        borrow = 1'b1;
      end else begin
        kcnt_d = kcnt_q - 1'b1;
      end
    end
  end

  // A pulse issued in the same edge as a new carry/borrow nets out before clamping.
  always_comb begin
    issue    = (state_q == IDLE) && enable && (pend_q != 3'sd0);
    pend_sum = {{2{pend_q[2]}}, pend_q};
    if (carry)  pend_sum = pend_sum + 5'sd1;
    if (borrow) pend_sum = pend_sum - 5'sd1;
    if (issue)  pend_sum = pend_q[2] ? pend_sum + 5'sd1 : pend_sum - 5'sd1;
    drop   = 1'b0;
    pend_d = pend_sum[2:0];
    if (pend_sum > PMAX) begin
      pend_d = PMAX[2:0];
      drop   = 1'b1;
    end else if (pend_sum < PMIN) begin
      pend_d = PMIN[2:0];
      drop   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      kcnt_q  <= K_MID;
      gap_q   <= '0;
      pend_q  <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      state_q <= IDLE;
      kcnt_q  <= K_MID;
      gap_q   <= '0;
      pend_q  <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      kcnt_q <= kcnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_q | drop;
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
      case (state_q)
        IDLE: if (issue) begin
          state_q <= PULSE;
          inc_q   <= !pend_q[2];
          dec_q   <= pend_q[2];
        end
        PULSE: begin
          state_q <= GAP;
          gap_q   <= GW'(MIN_GAP - 1);
        end
        GAP: begin
          if (gap_q == '0) state_q <= IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inc     = inc_q;
  assign dec     = dec_q;
  assign pending = pend_q;
  assign busy    = (state_q != IDLE);
  assign ovf     = ovf_q;

`ifdef IDC_LOCK_DET_EN
  localparam int QW = $clog2(LOCK_CYCLES + 1);
  logic [QW-1:0] quiet_q;
  logic          lock_q;

  // Quiet counter saturates at LOCK_CYCLES; lock rises on the edge it gets there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quiet_q <= '0;
      lock_q  <= 1'b0;
    end else if (clr || carry || borrow) begin
      quiet_q <= '0;
      lock_q  <= 1'b0;
    end else if (quiet_q < QW'(LOCK_CYCLES)) begin
      quiet_q <= quiet_q + 1'b1;
      lock_q  <= (quiet_q >= QW'(LOCK_CYCLES - 1));
    end
  end
  assign lock = lock_q;
`else
  assign lock = (LOCK_CYCLES < 0);
`endif
endmodule

// File: tb/tb_idc_pulse_scheduler.sv
// Scoreboard bench for idc_pulse_scheduler: stimulus pushes expected pulse kinds, a monitor pops them per pulse.
module tb_idc_pulse_scheduler;
  localparam int MIN_GAP = 40;

  logic clk = 1'b0, reset = 1'b0, enable = 1'b0, clr = 1'b0, up = 1'b0, dn = 1'b0;
  logic inc, dec, busy, ovf, lock;
  logic signed [2:0] pending;

  idc_pulse_scheduler #(.MIN_GAP(MIN_GAP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clr(clr), .up(up), .dn(dn),
    .inc(inc), .dec(dec), .pending(pending), .busy(busy), .ovf(ovf), .lock(lock)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int low_cnt = 1000;
  bit exp_q[$];  // 1 = inc pulse expected, 0 = dec pulse expected

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      low_cnt = 1000;
    end else if (inc || dec) begin
      chk("inc_dec_exclusive", int'(inc && dec), 0);
      if (exp_q.size() == 0) chk("unexpected_pulse", int'(inc), -1);
      else chk("pulse_kind_is_inc", int'(inc), int'(exp_q.pop_front()));
      chk("gap_ok", int'(low_cnt >= MIN_GAP), 1);
      low_cnt = 0;
    end else begin
      low_cnt++;
    end
  end

  task automatic step(input bit e, input bit u, input bit d);
    enable = e; up = u; dn = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    repeat (3) @(negedge clk);
    chk("rst_inc", int'(inc), 0);
    chk("rst_pending", int'(pending), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_inc", int'(inc), 0);
    chk("rel_dec", int'(dec), 0);
    chk("rel_busy", int'(busy), 0);
    chk("rel_ovf", int'(ovf), 0);
    chk("rel_lock", int'(lock), 0);
    chk("rel_pending", int'(pending), 0);

    // 2: nine ups -> one carry, one inc pulse a cycle later
    exp_q.push_back(1'b1);
    repeat (8) step(1'b1, 1'b1, 1'b0);
    chk("t2_pend_pre", int'(pending), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("t2_pend_carry", int'(pending), 1);
    chk("t2_inc_not_yet", int'(inc), 0);
    step(1'b1, 1'b0, 1'b0);
    chk("t2_inc_high", int'(inc), 1);
    chk("t2_pend_issued", int'(pending), 0);
    chk("t2_busy", int'(busy), 1);
    step(1'b1, 1'b0, 1'b0);
    chk("t2_inc_one_cycle", int'(inc), 0);
    idle(50);
    chk("t2_pend_end", int'(pending), 0);
    chk("t2_busy_end", int'(busy), 0);

    // 3: kcnt back at 7 -> eight dn borrow; up&dn together does nothing
    exp_q.push_back(1'b0);
    repeat (8) step(1'b1, 1'b0, 1'b1);
    chk("t3_pend_borrow", int'(pending), -1);
    step(1'b1, 1'b0, 1'b0);
    chk("t3_dec_high", int'(dec), 1);
    idle(50);
    repeat (20) step(1'b1, 1'b1, 1'b1);
    idle(5);
    chk("t3_pend_end", int'(pending), 0);
    chk("t3_ovf", int'(ovf), 0);

    // 4: 45 ups with a long gap -> saturation at +3 and one dropped carry
    do_reset();
    repeat (4) exp_q.push_back(1'b1);
    for (int i = 1; i <= 45; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i == 9)  chk("t4_pend_e9", int'(pending), 1);
      if (i == 18) chk("t4_pend_e18", int'(pending), 1);
      if (i == 27) chk("t4_pend_e27", int'(pending), 2);
      if (i == 36) begin
        chk("t4_pend_e36", int'(pending), 3);
        chk("t4_ovf_e36", int'(ovf), 0);
      end
      if (i == 45) begin
        chk("t4_pend_e45", int'(pending), 3);
        chk("t4_ovf_e45", int'(ovf), 1);
      end
    end
    idle(160);
    chk("t4_pend_end", int'(pending), 0);
    chk("t4_ovf_sticky", int'(ovf), 1);
    chk("t4_busy_end", int'(busy), 0);

    // 5a: async reset with pending=+2 during GAP
    do_reset();
    exp_q.push_back(1'b1);
    repeat (27) step(1'b1, 1'b1, 1'b0);
    chk("t5_pend_pre", int'(pending), 2);
    chk("t5_busy_pre", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_inc", int'(inc), 0);
    chk("t5_rst_dec", int'(dec), 0);
    chk("t5_rst_pending", int'(pending), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_ovf", int'(ovf), 0);
    @(negedge clk);
    reset = 1'b1;
    idle(60);
    chk("t5_pend_after", int'(pending), 0);

    // 5b: same with a one-cycle clr
    exp_q.push_back(1'b1);
    repeat (27) step(1'b1, 1'b1, 1'b0);
    chk("t5c_pend_pre", int'(pending), 2);
    chk("t5c_busy_pre", int'(busy), 1);
    clr = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    clr = 1'b0;
    chk("t5c_pending", int'(pending), 0);
    chk("t5c_busy", int'(busy), 0);
    chk("t5c_inc", int'(inc), 0);
    idle(60);
    chk("t5c_pend_after", int'(pending), 0);

    // 6: lock after 64 quiet cycles, dropped on the next carry
    do_reset();
    idle(63);
    chk("t6_lock_63", int'(lock), 0);
    idle(1);
`ifdef IDC_LOCK_DET_EN
    chk("t6_lock_64", int'(lock), 1);
`else
    chk("t6_lock_tied", int'(lock), 0);
`endif
    exp_q.push_back(1'b1);
    repeat (8) step(1'b1, 1'b1, 1'b0);
`ifdef IDC_LOCK_DET_EN
    chk("t6_lock_held", int'(lock), 1);
`endif
    step(1'b1, 1'b1, 1'b0);
    chk("t6_lock_carry", int'(lock), 0);
    chk("t6_pend_carry", int'(pending), 1);
    idle(50);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
